// File: rtl/ddr3_port_arbiter.sv
// Two-port burst arbiter in front of the DDR3 controller: round-robin between the
// acquisition (A) and USB (B) ports, with urgent A priority bounded by a starvation limit.
module ddr3_port_arbiter #(
   parameter int ADDR_WIDTH = 27,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_BITS   = 8,
   parameter int STARVE_MAX = 4
) (
   input  logic                  clock,
   input  logic                  arst_n,
   input  logic                  urgent_i,
   input  logic                  a_cmd_valid,
   output logic                  a_cmd_ready,
   input  logic                  a_cmd_write,
   input  logic [ADDR_WIDTH-1:0] a_cmd_addr,
   input  logic [LEN_BITS-1:0]   a_cmd_len,
   input  logic                  a_wr_valid,
   output logic                  a_wr_ready,
   input  logic [DATA_WIDTH-1:0] a_wr_data,
   output logic                  a_rd_valid,
   input  logic                  a_rd_ready,
   output logic                  a_rd_last,
   output logic [DATA_WIDTH-1:0] a_rd_data,
   input  logic                  b_cmd_valid,
   output logic                  b_cmd_ready,
   input  logic                  b_cmd_write,
   input  logic [ADDR_WIDTH-1:0] b_cmd_addr,
   input  logic [LEN_BITS-1:0]   b_cmd_len,
   input  logic                  b_wr_valid,
   output logic                  b_wr_ready,
   input  logic [DATA_WIDTH-1:0] b_wr_data,
   output logic                  b_rd_valid,
   input  logic                  b_rd_ready,
   output logic                  b_rd_last,
   output logic [DATA_WIDTH-1:0] b_rd_data,
   output logic                  m_cmd_valid,
   input  logic                  m_cmd_ready,
   output logic                  m_cmd_write,
   output logic [ADDR_WIDTH-1:0] m_cmd_addr,
   output logic [LEN_BITS-1:0]   m_cmd_len,
   output logic                  m_wr_valid,
   input  logic                  m_wr_ready,
   output logic                  m_wr_last,
   output logic [DATA_WIDTH-1:0] m_wr_data,
   input  logic                  m_rd_valid,
   output logic                  m_rd_ready,
   input  logic                  m_rd_last,
   input  logic [DATA_WIDTH-1:0] m_rd_data,
   output logic [1:0]            grant_o,
   output logic                  busy_o,
   output logic                  err_o
);

   localparam int SW = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {S_IDLE, S_CMD, S_WDATA, S_RDATA} state_t;

   state_t              state;
   logic                prio_b;
   logic [SW-1:0]       starve_cnt;
   logic [LEN_BITS-1:0] beat_cnt;
   logic                pick_a, pick_b;
   logic                is_last, sel_b, in_wr, in_rd, wr_hs, rd_hs;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      pick_a = 1'b0;
      pick_b = 1'b0;
      if (state == S_IDLE) begin
         if (a_cmd_valid && b_cmd_valid) begin
            pick_b = urgent_i ? (starve_cnt == SW'(STARVE_MAX)) : prio_b;
            pick_a = !pick_b;
         end else begin
            pick_a = a_cmd_valid;
            pick_b = b_cmd_valid;
         end
      end
   end

   assign a_cmd_ready = pick_a;
   assign b_cmd_ready = pick_b;

   // Data phases are pure routing; only the beat counter decides where the burst ends.
   assign is_last    = (beat_cnt == m_cmd_len);
   assign sel_b      = grant_o[1];
   assign in_wr      = (state == S_WDATA);
   assign in_rd      = (state == S_RDATA);

   assign m_wr_valid = in_wr && (sel_b ? b_wr_valid : a_wr_valid);
   assign m_wr_data  = sel_b ? b_wr_data : a_wr_data;
   assign m_wr_last  = in_wr && is_last;
   assign a_wr_ready = in_wr && !sel_b && m_wr_ready;
   assign b_wr_ready = in_wr && sel_b && m_wr_ready;

   assign m_rd_ready = in_rd && (sel_b ? b_rd_ready : a_rd_ready);
   assign a_rd_valid = in_rd && !sel_b && m_rd_valid;
   assign b_rd_valid = in_rd && sel_b && m_rd_valid;
   assign a_rd_last  = in_rd && !sel_b && is_last;
   assign b_rd_last  = in_rd && sel_b && is_last;
   assign a_rd_data  = m_rd_data;
   assign b_rd_data  = m_rd_data;

   assign wr_hs = m_wr_valid && m_wr_ready;
   assign rd_hs = m_rd_valid && m_rd_ready;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or negedge arst_n) begin
      if (!arst_n) begin
         state       <= S_IDLE;
         prio_b      <= 1'b0;
         starve_cnt  <= '0;
         beat_cnt    <= '0;
         m_cmd_valid <= 1'b0;
         m_cmd_write <= 1'b0;
         m_cmd_addr  <= '0;
         m_cmd_len   <= '0;
         grant_o     <= 2'b00;
         busy_o      <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pick_a || pick_b) begin
                  m_cmd_write <= pick_b ? b_cmd_write : a_cmd_write;
                  m_cmd_addr  <= pick_b ? b_cmd_addr : a_cmd_addr;
                  m_cmd_len   <= pick_b ? b_cmd_len : a_cmd_len;
                  m_cmd_valid <= 1'b1;
                  grant_o     <= {pick_b, pick_a};
                  busy_o      <= 1'b1;
                  prio_b      <= pick_a;
                  state       <= S_CMD;
                  // Only A grants that made a waiting B step aside count toward starvation.
                  if (pick_a && b_cmd_valid) begin
                     if (starve_cnt != SW'(STARVE_MAX)) starve_cnt <= starve_cnt + SW'(1);
                  end else begin
                     starve_cnt <= '0;
                  end
               end
            end
            S_CMD: begin
               if (m_cmd_ready) begin
                  m_cmd_valid <= 1'b0;
                  beat_cnt    <= '0;
                  state       <= m_cmd_write ? S_WDATA : S_RDATA;
               end
            end
            S_WDATA: begin
               if (wr_hs) begin
                  if (is_last) begin
                     state   <= S_IDLE;
                     grant_o <= 2'b00;
                     busy_o  <= 1'b0;
                  end else begin
                     beat_cnt <= beat_cnt + LEN_BITS'(1);
                  end
               end
            end
            S_RDATA: begin
               if (rd_hs) begin
                  if (m_rd_last != is_last) err_o <= 1'b1;
                  if (is_last) begin
                     state   <= S_IDLE;
                     grant_o <= 2'b00;
                     busy_o  <= 1'b0;
                  end else begin
                     beat_cnt <= beat_cnt + LEN_BITS'(1);
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Scoreboard bench for ddr3_port_arbiter: requester and controller models drive the DUT,
// expected commands and beats are queued at issue time and popped by a monitor.
module tb_ddr3_port_arbiter;

   localparam int AW = 27;
   localparam int DW = 32;
   localparam int LW = 8;

   typedef struct {
      logic [1:0]    grant;
      logic          write;
      logic [AW-1:0] addr;
      logic [LW-1:0] len;
   } cmd_t;
   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } wbeat_t;
   typedef struct {
      int            port;
      logic [DW-1:0] data;
      logic          last;
   } rbeat_t;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic          arst_n, urgent_i;
   logic [1:0]    cmd_valid, cmd_write, wr_valid, rd_ready;
   logic [AW-1:0] cmd_addr [2];
   logic [LW-1:0] cmd_len [2];
   logic [DW-1:0] wr_data [2];
   wire  [1:0]    cmd_ready, wr_ready, rd_valid, rd_last;
   wire  [DW-1:0] rd_data_a, rd_data_b;
   logic          m_cmd_ready, m_wr_ready, m_rd_valid, m_rd_last;
   logic [DW-1:0] m_rd_data;
   wire           m_cmd_valid, m_cmd_write, m_wr_valid, m_wr_last, m_rd_ready;
   wire  [AW-1:0] m_cmd_addr;
   wire  [LW-1:0] m_cmd_len;
   wire  [DW-1:0] m_wr_data;
   wire  [1:0]    grant_o;
   wire           busy_o, err_o;

   int     checks = 0;
   int     errors = 0;
   int     wr_seen = 0;
   int     abandoned = -1;
   bit     rand_mode = 1'b0;
   bit     bad_last = 1'b0;
   bit     rd_active = 1'b0;
   cmd_t   req_q [2][$];
   logic [DW-1:0] wq [2][$];
   cmd_t   exp_cmd [$];
   wbeat_t exp_wr [$];
   rbeat_t exp_rd [$];

   ddr3_port_arbiter dut (
      .clock(clock), .arst_n(arst_n), .urgent_i(urgent_i),
      .a_cmd_valid(cmd_valid[0]), .a_cmd_ready(cmd_ready[0]), .a_cmd_write(cmd_write[0]),
      .a_cmd_addr(cmd_addr[0]), .a_cmd_len(cmd_len[0]),
      .a_wr_valid(wr_valid[0]), .a_wr_ready(wr_ready[0]), .a_wr_data(wr_data[0]),
      .a_rd_valid(rd_valid[0]), .a_rd_ready(rd_ready[0]), .a_rd_last(rd_last[0]), .a_rd_data(rd_data_a),
      .b_cmd_valid(cmd_valid[1]), .b_cmd_ready(cmd_ready[1]), .b_cmd_write(cmd_write[1]),
      .b_cmd_addr(cmd_addr[1]), .b_cmd_len(cmd_len[1]),
      .b_wr_valid(wr_valid[1]), .b_wr_ready(wr_ready[1]), .b_wr_data(wr_data[1]),
      .b_rd_valid(rd_valid[1]), .b_rd_ready(rd_ready[1]), .b_rd_last(rd_last[1]), .b_rd_data(rd_data_b),
      .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_write(m_cmd_write),
      .m_cmd_addr(m_cmd_addr), .m_cmd_len(m_cmd_len),
      .m_wr_valid(m_wr_valid), .m_wr_ready(m_wr_ready), .m_wr_last(m_wr_last), .m_wr_data(m_wr_data),
      .m_rd_valid(m_rd_valid), .m_rd_ready(m_rd_ready), .m_rd_last(m_rd_last), .m_rd_data(m_rd_data),
      .grant_o(grant_o), .busy_o(busy_o), .err_o(err_o)
   );

   function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] addr, input logic [LW-1:0] i);
      return (DW'(addr) ^ 32'hA500_0000) + DW'(i);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic issue_req(input int p, input logic w, input logic [AW-1:0] a, input logic [LW-1:0] l);
      cmd_t c;
      c.grant = 2'b00; c.write = w; c.addr = a; c.len = l;
      req_q[p].push_back(c);
   endtask

   task automatic expect_burst(input int p, input logic w, input logic [AW-1:0] a, input logic [LW-1:0] l);
      cmd_t   c;
      wbeat_t wb;
      rbeat_t rb;
      c.grant = (p == 0) ? 2'b01 : 2'b10; c.write = w; c.addr = a; c.len = l;
      exp_cmd.push_back(c);
      for (int i = 0; i <= int'(l); i++) begin
         if (w) begin
            wb.data = beat_data(a, LW'(i)); wb.last = (i == int'(l));
            exp_wr.push_back(wb);
         end else begin
            rb.port = p; rb.data = beat_data(a, LW'(i)); rb.last = (i == int'(l));
            exp_rd.push_back(rb);
         end
      end
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (req_q[0].size() + req_q[1].size() + wq[0].size() + wq[1].size() +
             exp_cmd.size() + exp_wr.size() + exp_rd.size() != 0 || busy_o || rd_active) begin
         @(negedge clock);
         n++;
         if (n > 500) begin
            check({name, "_timeout"}, 64'd0, 64'd1);
            break;
         end
      end
      repeat (2) @(negedge clock);
   endtask

   // Requester model: holds each queued command until accepted, then streams its write beats.
   initial begin
      logic [1:0] c_hs, w_hs;
      cmd_t cur;
      cmd_valid = '0; cmd_write = '0; wr_valid = '0; rd_ready = 2'b11;
      for (int p = 0; p < 2; p++) begin
         cmd_addr[p] = '0; cmd_len[p] = '0; wr_data[p] = '0;
      end
      forever begin
         @(negedge clock);
         c_hs = cmd_valid & cmd_ready;
         w_hs = wr_valid & wr_ready;
         @(posedge clock);
         #1;
         for (int p = 0; p < 2; p++) begin
            if (!arst_n) begin
               req_q[p].delete();
               wq[p].delete();
            end else begin
               if (c_hs[p]) begin
                  cur = req_q[p].pop_front();
                  if (cur.write)
                     for (int i = 0; i <= int'(cur.len); i++) wq[p].push_back(beat_data(cur.addr, LW'(i)));
               end
               if (w_hs[p]) void'(wq[p].pop_front());
            end
            cmd_valid[p] = (req_q[p].size() > 0);
            if (req_q[p].size() > 0) begin
               cmd_write[p] = req_q[p][0].write;
               cmd_addr[p]  = req_q[p][0].addr;
               cmd_len[p]   = req_q[p][0].len;
            end
            wr_valid[p] = (wq[p].size() > 0);
            if (wq[p].size() > 0) wr_data[p] = wq[p][0];
         end
      end
   end

   // Controller model: answers read commands with addr-derived beats, optionally stalling.
   initial begin
      bit            c_hs, c_w, r_hs;
      logic [LW-1:0] c_len, rd_len, rd_beat;
      logic [AW-1:0] c_addr, rd_addr;
      rd_len = '0; rd_beat = '0; rd_addr = '0;
      m_cmd_ready = 1'b0; m_wr_ready = 1'b0; m_rd_valid = 1'b0; m_rd_last = 1'b0; m_rd_data = '0;
      forever begin
         @(negedge clock);
         c_hs = m_cmd_valid && m_cmd_ready;
         c_w = m_cmd_write; c_len = m_cmd_len; c_addr = m_cmd_addr;
         r_hs = m_rd_valid && m_rd_ready;
         @(posedge clock);
         #1;
         if (!arst_n) begin
            rd_active = 1'b0;
         end else begin
            if (r_hs) begin
               if (rd_beat == rd_len) rd_active = 1'b0;
               else rd_beat = rd_beat + LW'(1);
            end
            if (c_hs && !c_w) begin
               rd_active = 1'b1; rd_beat = '0; rd_len = c_len; rd_addr = c_addr;
            end
         end
         m_cmd_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
         m_wr_ready  = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
         m_rd_valid  = rd_active && (rand_mode ? 1'($urandom_range(0, 1)) : 1'b1);
         m_rd_data   = beat_data(rd_addr, rd_beat);
         m_rd_last   = bad_last ? (rd_beat == LW'(1)) : (rd_beat == rd_len);
      end
   end

   // Monitor: every handshake the DUT presents is compared against the head of its queue.
   initial begin
      cmd_t   e;
      wbeat_t wb;
      rbeat_t rb;
      forever begin
         @(negedge clock);
         if (!arst_n) begin
            if (exp_wr.size() != 0) abandoned = exp_wr.size();
            exp_cmd.delete(); exp_wr.delete(); exp_rd.delete();
         end else begin
            if (m_cmd_valid && m_cmd_ready) begin
               if (exp_cmd.size() == 0) check("cmd_extra", 64'd1, 64'd0);
               else begin
                  e = exp_cmd.pop_front();
                  check("cmd_grant", grant_o, e.grant);
                  check("cmd_write", m_cmd_write, e.write);
                  check("cmd_addr", m_cmd_addr, e.addr);
                  check("cmd_len", m_cmd_len, e.len);
               end
            end
            if (m_wr_valid && m_wr_ready) begin
               wr_seen++;
               if (exp_wr.size() == 0) check("wr_extra", 64'd1, 64'd0);
               else begin
                  wb = exp_wr.pop_front();
                  check("wr_data", m_wr_data, wb.data);
                  check("wr_last", m_wr_last, wb.last);
               end
            end
            for (int p = 0; p < 2; p++) begin
               if (rd_valid[p] && rd_ready[p]) begin
                  if (exp_rd.size() == 0) check("rd_extra", 64'd1, 64'd0);
                  else begin
                     rb = exp_rd.pop_front();
                     check("rd_port", p, rb.port);
                     check("rd_data", (p == 0) ? rd_data_a : rd_data_b, rb.data);
                     check("rd_last", rd_last[p], rb.last);
                  end
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int base;
      arst_n = 1'b0; urgent_i = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_grant", grant_o, 2'b00);
      check("rst_busy", busy_o, 1'b0);
      check("rst_err", err_o, 1'b0);
      check("rst_m_cmd_valid", m_cmd_valid, 1'b0);
      check("rst_cmd_ready", cmd_ready, 2'b00);
      check("rst_m_rd_ready", m_rd_ready, 1'b0);
      arst_n = 1'b1;
      repeat (2) @(negedge clock);

      // Round-robin with both ports requesting single-beat reads.
      issue_req(0, 1'b0, 27'h200, 8'd0); issue_req(0, 1'b0, 27'h201, 8'd0);
      issue_req(1, 1'b0, 27'h280, 8'd0); issue_req(1, 1'b0, 27'h281, 8'd0);
      expect_burst(0, 1'b0, 27'h200, 8'd0); expect_burst(1, 1'b0, 27'h280, 8'd0);
      expect_burst(0, 1'b0, 27'h201, 8'd0); expect_burst(1, 1'b0, 27'h281, 8'd0);
      wait_idle("alternate");

      // Urgent A, bounded by the starvation limit of 4.
      urgent_i = 1'b1;
      for (int k = 0; k < 10; k++) issue_req(0, 1'b0, AW'(32'h300 + k), 8'd0);
      issue_req(1, 1'b0, 27'h380, 8'd0); issue_req(1, 1'b0, 27'h381, 8'd0);
      for (int k = 0; k < 4; k++) expect_burst(0, 1'b0, AW'(32'h300 + k), 8'd0);
      expect_burst(1, 1'b0, 27'h380, 8'd0);
      for (int k = 4; k < 8; k++) expect_burst(0, 1'b0, AW'(32'h300 + k), 8'd0);
      expect_burst(1, 1'b0, 27'h381, 8'd0);
      expect_burst(0, 1'b0, 27'h308, 8'd0); expect_burst(0, 1'b0, 27'h309, 8'd0);
      wait_idle("urgent");
      urgent_i = 1'b0;

      // Lone A write: ready for one cycle, command one cycle later.
      issue_req(0, 1'b1, 27'h100, 8'd3);
      expect_burst(0, 1'b1, 27'h100, 8'd3);
      n = 0;
      while (!cmd_ready[0] && n < 20) begin
         @(negedge clock);
         n++;
      end
      check("a_ready_seen", cmd_ready[0], 1'b1);
      check("m_cmd_not_yet", m_cmd_valid, 1'b0);
      check("grant_before", grant_o, 2'b00);
      @(negedge clock);
      check("a_ready_once", cmd_ready[0], 1'b0);
      check("m_cmd_next", m_cmd_valid, 1'b1);
      check("grant_a", grant_o, 2'b01);
      check("busy_cmd", busy_o, 1'b1);
      wait_idle("write_a");
      check("grant_idle", grant_o, 2'b00);
      check("busy_idle", busy_o, 1'b0);

      // Long bursts under random controller stalls; B goes first since A was granted last.
      rand_mode = 1'b1;
      issue_req(0, 1'b1, 27'h400, 8'd7); issue_req(1, 1'b0, 27'h480, 8'd7);
      expect_burst(1, 1'b0, 27'h480, 8'd7); expect_burst(0, 1'b1, 27'h400, 8'd7);
      wait_idle("stall_mix");
      issue_req(0, 1'b0, 27'h500, 8'd7);
      expect_burst(0, 1'b0, 27'h500, 8'd7);
      wait_idle("stall_read");
      rand_mode = 1'b0;

      // Controller signals last too early; the counter still ends the burst.
      check("err_before", err_o, 1'b0);
      bad_last = 1'b1;
      issue_req(0, 1'b0, 27'h600, 8'd3);
      expect_burst(0, 1'b0, 27'h600, 8'd3);
      wait_idle("bad_last");
      check("err_set", err_o, 1'b1);
      bad_last = 1'b0;
      issue_req(0, 1'b0, 27'h610, 8'd0);
      expect_burst(0, 1'b0, 27'h610, 8'd0);
      wait_idle("after_err");
      check("err_sticky", err_o, 1'b1);

      // Reset in the middle of an 8-beat write.
      base = wr_seen;
      issue_req(0, 1'b1, 27'h700, 8'd7);
      expect_burst(0, 1'b1, 27'h700, 8'd7);
      n = 0;
      while (wr_seen < base + 2 && n < 100) begin
         @(posedge clock);
         n++;
      end
      check("mid_write_reached", wr_seen - base, 2);
      #2 arst_n = 1'b0;
      #1;
      check("mrst_grant", grant_o, 2'b00);
      check("mrst_busy", busy_o, 1'b0);
      check("mrst_err", err_o, 1'b0);
      check("mrst_m_cmd_valid", m_cmd_valid, 1'b0);
      check("mrst_m_wr_valid", m_wr_valid, 1'b0);
      check("mrst_m_wr_last", m_wr_last, 1'b0);
      check("mrst_wr_ready", wr_ready, 2'b00);
      repeat (3) @(negedge clock);
      check("abandoned_beats", abandoned, 6);
      arst_n = 1'b1;
      repeat (2) @(negedge clock);
      issue_req(1, 1'b0, 27'h780, 8'd0);
      expect_burst(1, 1'b0, 27'h780, 8'd0);
      wait_idle("post_reset_b");
      check("final_grant", grant_o, 2'b00);
      check("leftover", exp_cmd.size() + exp_wr.size() + exp_rd.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
